// File: rtl/pc_sequencer.sv
// Fetch sequencer: computes program_counter's next value, runs the imem request/ack port
// and hands instructions to decode. Optional MISALIGN_TRAP_EN redirects misaligned targets to TRAP_VECTOR.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        decode_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        misalign_trap,
    output logic [1:0]  state_dbg
);

    // Handshakes: an imem transfer completes on any cycle with imem_req & imem_ack, and
    // imem_req/imem_addr never change before that. Decode takes an instruction on
    // instr_valid & decode_ready; instr/instr_pc hold until then, unless a redirect discards it.
    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

    state_t      state;
    logic        trap_sel;
    logic [31:0] redir_dest;
    logic [31:0] pc_seq;

`ifdef MISALIGN_TRAP_EN
    assign trap_sel = redirect_target[1:0] != 2'b00;
`else
    logic unused_target_lsbs;
    assign unused_target_lsbs = |redirect_target[1:0];
    assign trap_sel           = 1'b0;
`endif

    // Low bits are cleared unconditionally; with trapping enabled they are already zero here.
    assign redir_dest = trap_sel ? TRAP_VECTOR : {redirect_target[31:2], 2'b00};
    assign pc_seq     = pc_cur + 32'd4;
    assign state_dbg  = state;

    // program_counter has no enable, so the default is to reload its own value.
    always_comb begin
        pc_next = pc_cur;
        if (rst || state == BOOT) begin
            pc_next = RESET_VECTOR;
        end else if (redirect_valid) begin
            pc_next = redir_dest;
        end else if (state == HOLD && decode_ready) begin
            pc_next = pc_seq;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BOOT;
            imem_req      <= 1'b0;
            imem_addr     <= RESET_VECTOR;
            instr_valid   <= 1'b0;
            instr         <= 32'd0;
            instr_pc      <= 32'd0;
            misalign_trap <= 1'b0;
        end else begin
            misalign_trap <= redirect_valid && trap_sel && (state != BOOT);
            case (state)
                BOOT: begin
                    imem_req  <= 1'b1;
                    imem_addr <= pc_next;
                    state     <= FETCH;
                end
                FETCH: begin
                    if (redirect_valid) begin
                        // A response arriving with the redirect is stale; refetch at once.
                        if (imem_ack) begin
                            imem_addr <= pc_next;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= imem_addr;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_valid || decode_ready) begin
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        imem_addr   <= pc_next;
                        state       <= FETCH;
                    end
                end
                DRAIN: begin
                    // pc_cur already holds the latest redirect destination.
                    if (imem_ack) begin
                        imem_addr <= pc_next;
                        state     <= FETCH;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: models program_counter and an imem responder,
// scoreboards delivered instructions against an expected address queue.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
`ifdef MISALIGN_TRAP_EN
    localparam logic        TRAP_ON = 1'b1;
`else
    localparam logic        TRAP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_cur = 32'd0;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        decode_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        misalign_trap;
    logic [1:0]  state_dbg;

    logic [31:0] exp_q[$];
    int          n_total = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          mem_lat = 0;
    int          mem_cnt = 0;
    bit          rand_mem = 1'b0;
    bit          rate_chk = 1'b0;
    int          last_acc = -1;

    pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .decode_ready(decode_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .misalign_trap(misalign_trap), .state_dbg(state_dbg)
    );

    // clock / program_counter model
    always #5 clk = ~clk;
    always @(posedge clk) begin
        pc_cur <= pc_next;
        cyc    <= cyc + 1;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle, then let the memory model answer the current request.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst || !imem_req) begin
            mem_cnt    = 0;
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
        end else if (rand_mem ? ($urandom_range(0, 2) == 0) : (mem_cnt >= mem_lat)) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            mem_cnt    = 0;
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            mem_cnt++;
        end
    endtask

    // Leaves the bench in cycle 0 (BOOT) with rst released.
    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        decode_ready = 1'b0;
        repeat (3) tick();
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_trap", misalign_trap, 1'b0);
        check("rst_addr", imem_addr, RV);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_state", state_dbg, 2'd0);
        rst = 1'b0;
    endtask

    task automatic redirect_now(input logic [31:0] t, input logic [31:0] exp_next);
        redirect_valid  = 1'b1;
        redirect_target = t;
        #1;
        check("redir_pc_next", pc_next, exp_next);
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic run_q(input int budget, input bit rnd);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            decode_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        decode_ready = 1'b0;
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: scoreboard on decode handoff, plus hold/stability checks.
    logic        p_req = 0, p_ack = 0, p_valid = 0, p_ready = 0, p_redir = 0, p_rst = 1;
    logic [31:0] p_addr = 0, p_instr = 0, p_ipc = 0;
    always @(negedge clk) begin
        if (rst) begin
            check("pc_next_rst", pc_next, RV);
        end else begin
            if (p_req && !p_ack && !p_rst) begin
                check("req_hold", imem_req, 1'b1);
                check("addr_hold", imem_addr, p_addr);
            end
            if (p_valid && !p_ready && !p_redir && !p_rst) begin
                check("valid_hold", instr_valid, 1'b1);
                check("instr_hold", instr, p_instr);
                check("instr_pc_hold", instr_pc, p_ipc);
            end
            if (instr_valid && decode_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_accept", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc, e);
                    check("instr", instr, mem_word(e));
                end
                if (rate_chk) begin
                    if (last_acc >= 0) check("accept_gap", cyc - last_acc, 32'd2);
                    last_acc = cyc;
                end
            end
        end
        p_req = imem_req; p_ack = imem_ack; p_valid = instr_valid; p_ready = decode_ready;
        p_redir = redirect_valid; p_rst = rst; p_addr = imem_addr; p_instr = instr; p_ipc = instr_pc;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // zero-wait memory, decode always ready: sequential stream, one per 2 cycles
        mem_lat = 0;
        do_reset();
        #1 check("boot_pc_next", pc_next, RV);
        rate_chk = 1'b1; last_acc = -1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        run_q(50, 1'b0);
        rate_chk = 1'b0;

        // boot timing, slow memory and decode stalls in HOLD
        mem_lat = 3;
        do_reset();
        tick();
        check("boot_req", imem_req, 1'b1);
        check("boot_pc_cur", pc_cur, RV);
        check("boot_addr", imem_addr, RV);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        begin
            int n = 0;
            int h = 0;
            while (exp_q.size() != 0 && n < 200) begin
                tick();
                n++;
                if (instr_valid) begin
                    if (h < 4) begin decode_ready = 1'b0; h++; end
                    else begin decode_ready = 1'b1; h = 0; end
                end else begin
                    decode_ready = 1'b0;
                end
            end
            decode_ready = 1'b0;
            check("hold_left", 32'(exp_q.size()), 32'd0);
        end

        // redirect with a request outstanding; stale ack two cycles later
        mem_lat = 2;
        do_reset();
        tick();
        redirect_now(32'h200, 32'h200);
        check("drain_req", imem_req, 1'b1);
        check("drain_addr", imem_addr, RV);
        tick();
        check("drain_pc_next", pc_next, 32'h200);
        tick();
        check("post_drain_addr", imem_addr, 32'h200);
        check("post_drain_req", imem_req, 1'b1);
        check("post_drain_valid", instr_valid, 1'b0);
        exp_q.push_back(32'h200); exp_q.push_back(32'h204);
        run_q(50, 1'b0);

        // redirect in HOLD with decode_ready high: instruction discarded
        mem_lat = 0;
        do_reset();
        tick();
        tick();
        check("hold_valid", instr_valid, 1'b1);
        check("hold_instr_pc", instr_pc, RV);
        decode_ready = 1'b1;
        redirect_now(32'h300, 32'h300);
        decode_ready = 1'b0;
        check("hredir_valid", instr_valid, 1'b0);
        check("hredir_req", imem_req, 1'b1);
        check("hredir_addr", imem_addr, 32'h300);
        check("hredir_trap", misalign_trap, 1'b0);
        exp_q.push_back(32'h300);
        run_q(50, 1'b0);

        // redirect coincident with ack in FETCH
        do_reset();
        tick();
        check("coinc_ack", imem_ack, 1'b1);
        redirect_now(32'h400, 32'h400);
        check("coinc_req", imem_req, 1'b1);
        check("coinc_addr", imem_addr, 32'h400);
        check("coinc_valid", instr_valid, 1'b0);
        exp_q.push_back(32'h400);
        run_q(50, 1'b0);

        // PC wrap at top of address space
        do_reset();
        tick();
        redirect_now(32'hFFFF_FFFC, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        run_q(50, 1'b0);

        // misaligned redirect targets
        do_reset();
        tick();
        tick();
        redirect_now(32'h102, 32'h100);
        check("mis_trap_pulse", misalign_trap, TRAP_ON);
        check("mis_addr", imem_addr, 32'h100);
        tick();
        check("mis_trap_end", misalign_trap, 1'b0);
        exp_q.push_back(32'h100);
        run_q(50, 1'b0);

        do_reset();
        tick();
        tick();
        redirect_now(32'h206, TRAP_ON ? TV : 32'h204);
        check("mis2_trap_pulse", misalign_trap, TRAP_ON);
        exp_q.push_back(TRAP_ON ? TV : 32'h204);
        run_q(50, 1'b0);

        // reset while draining
        mem_lat = 5;
        do_reset();
        tick();
        redirect_now(32'h500, 32'h500);
        check("rdrain_state", state_dbg, 2'd3);
        rst = 1'b1;
        tick();
        check("rdrain_req", imem_req, 1'b0);
        check("rdrain_valid", instr_valid, 1'b0);
        rst = 1'b0;
        mem_lat = 0;
        tick();
        check("rdrain_boot_addr", imem_addr, RV);
        check("rdrain_boot_req", imem_req, 1'b1);
        exp_q.push_back(RV);
        run_q(50, 1'b0);

        // random memory latency and decode backpressure
        rand_mem = 1'b1;
        do_reset();
        for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
        run_q(1000, 1'b1);
        rand_mem = 1'b0;

        repeat (4) tick();
        check("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
